// File: rtl/health_alarm_arbiter.sv
// health_alarm_arbiter
// Shares one patient-alarm output among NUM_SRC abnormality detectors.
// Each source has a sticky 2-bit pending severity. A small FSM presents one
// alarm at a time. It picks the highest severity first, and breaks ties
// round-robin from a rotating pointer. An alarm ends on a nurse acknowledge
// or on a hold timeout, and is always followed by at least one quiet cycle.
//
// Optional feature macro: ALARM_MISS_COUNT_EN adds the o_miss_count port,
// an 8-bit saturating count of hold timeouts.
//
// Handshake: i_ack is a single-cycle pulse. It is acted on only while
// o_alarm_valid is high (SHOW). The edge that samples i_ack=1 ends the alarm,
// and o_alarm_valid is low after that edge. While o_alarm_valid is high,
// o_alarm_src and o_alarm_level are stable.

module health_alarm_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [2*NUM_SRC-1:0] i_abn,
  input  logic                 i_ack,
  output logic                 o_alarm_valid,
  output logic [SRC_W-1:0]     o_alarm_src,
  output logic [1:0]           o_alarm_level,
  output logic [NUM_SRC-1:0]   o_pending,
  output logic [1:0]           o_dbg_state
`ifdef ALARM_MISS_COUNT_EN
  ,
  output logic [7:0]           o_miss_count
`endif
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_alarm_valid;
  logic [SRC_W-1:0]  r_alarm_src;
  logic [1:0]        r_alarm_level;
  logic [HOLD_W-1:0] r_hold;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [1:0]        r_pend [NUM_SRC];
`ifdef ALARM_MISS_COUNT_EN
  logic [7:0]        r_miss;
`endif

  logic [1:0]        w_abn      [NUM_SRC];
  logic [1:0]        w_pend_max [NUM_SRC];
  logic [NUM_SRC-1:0] w_pending;
  logic              w_any;
  logic [1:0]        w_max_lvl;
  logic [SRC_W-1:0]  w_sel_src;
  logic              w_found;
  logic              w_ack_show;
  logic              w_timeout;
  logic [SRC_W-1:0]  w_rr_next;

  // Unpack the severities, form the sticky max per source, and flag the nonzero ones.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_abn[i]      = i_abn[2*i +: 2];
      w_pend_max[i] = (w_abn[i] > r_pend[i]) ? w_abn[i] : r_pend[i];
      w_pending[i]  = |r_pend[i];
    end
  end

  assign w_any = |w_pending;

  // Find the highest pending level, then the first source at that level at or after rr_ptr.
  always_comb begin
    w_max_lvl = 2'd0;
    w_sel_src = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_pend[i] > w_max_lvl) w_max_lvl = r_pend[i];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!w_found && (r_pend[idx] == w_max_lvl)) begin
        w_found   = 1'b1;
        w_sel_src = SRC_W'(idx);
      end
    end
  end

  assign w_ack_show = (r_state == ST_SHOW) && i_ack;
  assign w_timeout  = (r_state == ST_SHOW) && !i_ack &&
                      (r_hold == HOLD_W'(HOLD_CYCLES - 1));
  assign w_rr_next  = (r_alarm_src == SRC_W'(NUM_SRC - 1)) ? '0 : r_alarm_src + 1'b1;

  // Pending store: sticky max. An ack on the shown source reloads it from the live
  // severity, unless the source escalated past the shown level while on display.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) r_pend[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_ack_show && (r_alarm_src == SRC_W'(i)) && !(r_pend[i] > r_alarm_level)) begin
          r_pend[i] <= w_abn[i];
        end else begin
          r_pend[i] <= w_pend_max[i];
        end
      end
    end
  end

  // Presentation FSM: IDLE -> SHOW (captured source/level) -> GAP -> IDLE.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_alarm_valid <= 1'b0;
      r_alarm_src   <= '0;
      r_alarm_level <= 2'd0;
      r_hold        <= '0;
      r_rr_ptr      <= '0;
`ifdef ALARM_MISS_COUNT_EN
      r_miss        <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state       <= ST_SHOW;
            r_alarm_valid <= 1'b1;
            r_alarm_src   <= w_sel_src;
            r_alarm_level <= w_max_lvl;
            r_hold        <= '0;
          end
        end
        ST_SHOW: begin
          if (w_ack_show) begin
            r_state       <= ST_GAP;
            r_alarm_valid <= 1'b0;
            r_rr_ptr      <= w_rr_next;
          end else if (w_timeout) begin
            r_state       <= ST_GAP;
            r_alarm_valid <= 1'b0;
            r_rr_ptr      <= w_rr_next;
`ifdef ALARM_MISS_COUNT_EN
            if (r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
`endif
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_alarm_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_alarm_valid = r_alarm_valid;
  assign o_alarm_src   = r_alarm_src;
  assign o_alarm_level = r_alarm_level;
  assign o_pending     = w_pending;
  assign o_dbg_state   = r_state;
`ifdef ALARM_MISS_COUNT_EN
  assign o_miss_count  = r_miss;
`endif

endmodule

// File: tb/tb_health_alarm_arbiter.sv
// Directed bench for health_alarm_arbiter (NUM_SRC=4, HOLD_CYCLES=8).
// Expected grants {src, level} are queued when stimulus is driven and
// popped when an alarm appears.
module tb_health_alarm_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] abn;
  logic       ack;
  logic       alarm_valid;
  logic [1:0] alarm_src;
  logic [1:0] alarm_level;
  logic [3:0] pending;
  logic [1:0] dbg_state;
`ifdef ALARM_MISS_COUNT_EN
  logic [7:0] miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  health_alarm_arbiter #(.NUM_SRC(4), .HOLD_CYCLES(8)) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_abn         (abn),
    .i_ack         (ack),
    .o_alarm_valid (alarm_valid),
    .o_alarm_src   (alarm_src),
    .o_alarm_level (alarm_level),
    .o_pending     (pending),
    .o_dbg_state   (dbg_state)
`ifdef ALARM_MISS_COUNT_EN
    ,
    .o_miss_count  (miss_count)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    abn   = '0;
    ack   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_abn(input int src, input logic [1:0] lvl);
    abn[2*src +: 2] = lvl;
  endtask

  task automatic ack_pulse(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_drop"}, {31'd0, alarm_valid}, 32'd0);
  endtask

  // Scoreboard: wait (bounded) for an alarm and compare it with the queue head
  task automatic wait_alarm(input string tag, output int lows);
    logic [3:0] exp;
    lows = 0;
    while (!alarm_valid && lows < 20) begin
      tick();
      lows++;
    end
    chk({tag, "_seen"}, {31'd0, alarm_valid}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    chk({tag, "_grant"}, {28'd0, alarm_src, alarm_level}, {28'd0, exp});
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    while (alarm_valid && hi < 30) begin
      hi++;
      tick();
    end
  endtask

  initial begin
    int lows;
    int hi;
    rst_n = 1'b1;
    abn   = '0;
    ack   = 1'b0;
    tick();

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, alarm_valid}, 32'd0);
    chk("rst_src",   {30'd0, alarm_src}, 32'd0);
    chk("rst_level", {30'd0, alarm_level}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
`ifdef ALARM_MISS_COUNT_EN
    chk("rst_miss", {24'd0, miss_count}, 32'd0);
`endif
    do_reset();

    // Single event with exact latency
    set_abn(0, 2'd2);
    tick();
    abn = '0;
    chk("single_pending", {28'd0, pending}, 32'h1);
    chk("single_not_yet", {31'd0, alarm_valid}, 32'd0);
    tick();
    chk("single_valid_latency", {31'd0, alarm_valid}, 32'd1);
    exp_q.push_back({2'd0, 2'd2});
    wait_alarm("single", lows);
    ack_pulse("single");
    chk("single_cleared", {28'd0, pending}, 32'h0);

    // Severity priority: source 3 at 3 beats source 1 at 1
    do_reset();
    set_abn(1, 2'd1);
    set_abn(3, 2'd3);
    tick();
    abn = '0;
    exp_q.push_back({2'd3, 2'd3});
    exp_q.push_back({2'd1, 2'd1});
    wait_alarm("prio_first", lows);
    ack_pulse("prio_first");
    wait_alarm("prio_second", lows);
    chk("prio_gap_min", {31'd0, (lows >= 1)}, 32'd1);
    ack_pulse("prio_second");

    // Round-robin among equal severities, twice (pointer wraps 3 -> 0)
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_abn(0, 2'd2);
      set_abn(2, 2'd2);
      set_abn(3, 2'd2);
      tick();
      abn = '0;
      exp_q.push_back({2'd0, 2'd2});
      exp_q.push_back({2'd2, 2'd2});
      exp_q.push_back({2'd3, 2'd2});
      for (int g = 0; g < 3; g++) begin
        wait_alarm($sformatf("rr%0d_%0d", r, g), lows);
        ack_pulse($sformatf("rr%0d_%0d", r, g));
      end
      tick();
      chk($sformatf("rr%0d_empty", r), {28'd0, pending}, 32'h0);
    end

    // Timeout: source 2 at level 1, never acknowledged
    do_reset();
    set_abn(2, 2'd1);
    tick();
    abn = '0;
    exp_q.push_back({2'd2, 2'd1});
    wait_alarm("to1", lows);
    count_high(hi);
    chk("to1_hold_len", hi, 32'd8);
    chk("to1_low", {31'd0, alarm_valid}, 32'd0);
    chk("to1_pending", {28'd0, pending}, 32'h4);
`ifdef ALARM_MISS_COUNT_EN
    chk("to1_miss", {24'd0, miss_count}, 32'd1);
`endif
    exp_q.push_back({2'd2, 2'd1});
    wait_alarm("to2", lows);
    chk("to2_gap_min", {31'd0, (lows >= 1)}, 32'd1);
    count_high(hi);
    chk("to2_hold_len", hi, 32'd8);
`ifdef ALARM_MISS_COUNT_EN
    chk("to2_miss", {24'd0, miss_count}, 32'd2);
`endif

    // Escalation during SHOW: shown at 1, raised to 3, ack keeps pend at 3
    do_reset();
    set_abn(0, 2'd1);
    tick();
    abn = '0;
    exp_q.push_back({2'd0, 2'd1});
    wait_alarm("esc_first", lows);
    set_abn(0, 2'd3);
    tick();
    abn = '0;
    tick();
    chk("esc_stable_level", {30'd0, alarm_level}, 32'd1);
    ack_pulse("esc_first");
    chk("esc_pending_kept", {28'd0, pending}, 32'h1);
    exp_q.push_back({2'd0, 2'd3});
    wait_alarm("esc_again", lows);
    ack_pulse("esc_again");
    chk("esc_cleared", {28'd0, pending}, 32'h0);

    // Reset in the middle of an alarm
    do_reset();
    set_abn(1, 2'd2);
    set_abn(3, 2'd1);
    tick();
    abn = '0;
    chk("mid_pending", {28'd0, pending}, 32'hA);
    exp_q.push_back({2'd1, 2'd2});
    wait_alarm("mid_show", lows);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", {31'd0, alarm_valid}, 32'd0);
    chk("mid_async_pending", {28'd0, pending}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("mid_quiet_valid", {31'd0, alarm_valid}, 32'd0);
    chk("mid_quiet_pending", {28'd0, pending}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
